// File: rtl/alien_fleet.sv
// Space-invaders style alien formation: 4x8 alive mask, zig-zag motion FSM,
// per-cycle laser hit detection and a registered pixel colour for the VGA scan.
module alien_fleet #(
  parameter logic [2:0]  ALIEN_COLOR = 3'b010,
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned STEP_Y      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic [9:0] xLaser,
  input  logic [9:0] yLaser,
  output logic       killingAlien,
  output logic [2:0] colorAlien,
  output logic       aliensCleared,
  output logic       aliensLanded
);

  localparam logic [9:0] X_RESET  = 10'd8;
  localparam logic [9:0] Y_RESET  = 10'd40;
  localparam logic [9:0] X_MIN    = 10'd8;
  localparam logic [9:0] X_MAX    = 10'd392;
  localparam logic [9:0] Y_GROUND = 10'd328;
  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] STEP_X_W = 10'(STEP_X);
  localparam logic [9:0] STEP_Y_W = 10'(STEP_Y);

  typedef enum logic [2:0] {
    MOVE_RIGHT,
    MOVE_LEFT,
    STEP_DOWN,
    CLEARED,
    LANDED
  } state_t;

  state_t      state_q, state_d;
  logic        dir_left_q, dir_left_d;
  logic [9:0]  x_origin_q, x_origin_d;
  logic [9:0]  y_origin_q, y_origin_d;
  logic [31:0] alive_q, alive_d;
  logic        kill_q, kill_d;
  logic [2:0]  color_q, color_d;

  logic [5:0]  laser_loc;
  logic [5:0]  pix_loc;
  logic        active;
  logic [9:0]  x_right;
  logic [9:0]  y_down;

  // Returns {inside_box, row[1:0], col[2:0]}; a point left of / above the
  // origin, in a 16 px gap, or beyond the 8x4 grid is never inside.
  function automatic logic [5:0] locate(input logic [9:0] px, input logic [9:0] py,
                                        input logic [9:0] xo, input logic [9:0] yo);
    logic [9:0] dx;
    logic [9:0] dy;
    logic       ok;
    dx = px - xo;
    dy = py - yo;
    ok = (px >= xo) && (py >= yo) && (dx < 10'd256) && (dy < 10'd128) &&
         !dx[4] && !dy[4];
    return {ok, dy[6:5], dx[7:5]};
  endfunction

  always_comb begin
    state_d    = state_q;
    dir_left_d = dir_left_q;
    x_origin_d = x_origin_q;
    y_origin_d = y_origin_q;
    alive_d    = alive_q;
    kill_d     = 1'b0;
    color_d    = 3'b000;

    laser_loc = locate(xLaser, yLaser, x_origin_q, y_origin_q);
    pix_loc   = locate(hPos, vPos, x_origin_q, y_origin_q);
    active    = state_q inside {MOVE_RIGHT, MOVE_LEFT, STEP_DOWN};
    x_right   = x_origin_q + STEP_X_W;
    y_down    = y_origin_q + STEP_Y_W;

    if (active && (yLaser < SCREEN_H) && laser_loc[5] && alive_q[laser_loc[4:0]]) begin
      kill_d                   = 1'b1;
      alive_d[laser_loc[4:0]]  = 1'b0;
    end

    if ((hPos < SCREEN_W) && (vPos < SCREEN_H) && pix_loc[5] && alive_q[pix_loc[4:0]]) begin
      color_d = ALIEN_COLOR;
    end

    if (enable) begin
      case (state_q)
        MOVE_RIGHT: begin
          if (x_right > X_MAX) begin
            state_d    = STEP_DOWN;
            dir_left_d = 1'b1;
          end else begin
            x_origin_d = x_right;
          end
        end
        MOVE_LEFT: begin
          if (x_origin_q < X_MIN + STEP_X_W) begin
            state_d    = STEP_DOWN;
            dir_left_d = 1'b0;
          end else begin
            x_origin_d = x_origin_q - STEP_X_W;
          end
        end
        STEP_DOWN: begin
          y_origin_d = y_down;
          if (y_down >= Y_GROUND) begin
            state_d = LANDED;
          end else begin
            state_d = dir_left_q ? MOVE_LEFT : MOVE_RIGHT;
          end
        end
        default: ;
      endcase
    end

    // Landing outranks an empty formation when both happen together.
    if (active && (state_d != LANDED) && (alive_q == 32'd0)) begin
      state_d = CLEARED;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= MOVE_RIGHT;
      dir_left_q <= 1'b0;
      x_origin_q <= X_RESET;
      y_origin_q <= Y_RESET;
      alive_q    <= '1;
      kill_q     <= 1'b0;
      color_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      dir_left_q <= dir_left_d;
      x_origin_q <= x_origin_d;
      y_origin_q <= y_origin_d;
      alive_q    <= alive_d;
      kill_q     <= kill_d;
      color_q    <= color_d;
    end
  end

  assign killingAlien  = kill_q;
  assign colorAlien    = color_q;
  assign aliensCleared = (state_q == CLEARED);
  assign aliensLanded  = (state_q == LANDED);

endmodule
